uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Parametrised UART transmit framer. Successor to the fixed 8-bit, always-parity, one-stop-bit serializer.
- Adds configurable data width, runtime parity mode (none/even/odd) and 1 or 2 stop bits.
- Adds an input FIFO with valid/ready handshake, a transmit enable, and gap-free back-to-back frames.
- Sits between the host-side byte source and the TX pin. Runs entirely on baud_clk; one bit period per baud_clk cycle.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, FIFO word capacity; power of two, minimum 2.
- LVL_W, $clog2(FIFO_DEPTH+1), width of the fifo_level output (derived).

Ports:
- baud_clk  input  1  bit clock; one serial bit per rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_data  input  DATA_W  word to transmit.
- wr_valid  input  1  wr_data is valid this cycle.
- wr_ready  output  1  FIFO can accept a word (not full).
- tx_en  input  1  when 0, no new frame starts; a frame in progress completes.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
- stop2  input  1  1 = two stop bits, 0 = one stop bit.
- data_tx  output  1  serial line; idle high.
- active_flag  output  1  high while a frame is on the line.
- done_flag  output  1  one-cycle pulse at the end of each frame.
- overrun  output  1  one-cycle pulse when a write is dropped.
- fifo_level  output  LVL_W  words currently stored.

Behaviour:
- Reset (async, immediate): data_tx=1, active_flag=0, done_flag=0, overrun=0, fifo_level=0, wr_ready=1. FIFO is emptied and the FSM goes to IDLE. A reset mid-frame aborts the frame; the line returns high with no stop bit.
- FIFO push: on (wr_valid && wr_ready), the word is stored at the edge.
  - wr_ready = (fifo_level != FIFO_DEPTH), combinational from the level.
  - wr_valid while full: word dropped; overrun pulses high for 1 cycle; level unchanged.
  - There is no bypass. A word pushed into an empty FIFO can be popped no earlier than the next edge.
  - A push and a pop in the same cycle leave the level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
  - IDLE: data_tx=1, active_flag=0.
    - If tx_en && fifo_level!=0 at an edge: pop the word; latch it, parity_mode and stop2 into a frame register; set data_tx<=0 and active_flag<=1; go to START.
    - Config inputs are sampled only at pop. Changes mid-frame are ignored.
  - START: 1 cycle. data_tx<=bit0; go to DATA with bit_cnt=0.
  - DATA: DATA_W cycles, LSB first, shift register.
    - On the last bit: go to PARITY if mode is even/odd, else go to STOP.
  - PARITY: 1 cycle.
    - Even: bit = XOR of the DATA_W data bits.
    - Odd: bit = inverted XOR.
  - STOP: 1 cycle (stop2=0) or 2 cycles (stop2=1); data_tx=1.
    - At the final stop edge, done_flag<=1 for exactly one cycle.
    - If tx_en && FIFO non-empty: pop and go directly to START with data_tx<=0, active_flag stays 1 (back-to-back, zero idle bits).
    - Otherwise go to IDLE with active_flag<=0.
- Frame length = 1 + DATA_W + (parity?1:0) + (stop2?2:1) cycles. The first cycle of data_tx=0 is one cycle after the pop edge.
- tx_en deasserted mid-frame: the frame completes normally; no further pop.
- Reserved parity_mode 11 behaves exactly like 00.

Decomposition:
- Shared package uart_pkg:
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state enum (3-bit).
  - Idle line level constant MARK=1'b1.
- Sub-module uart_tx_fifo (synchronous FIFO, DATA_W x FIFO_DEPTH, push/pop/level/full/empty, async reset). The framer holds the FSM, shift register, bit counter and parity logic.

Test Plan:
- DATA_W=8, even parity, stop2=0, push 0xA5 -> data_tx over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; active_flag high for those 11 cycles; done_flag pulses once on the following cycle.
- Parity check with 0x01: odd parity -> parity bit 0; even parity -> parity bit 1. With none, the frame is 10 cycles with no parity slot.
- DATA_W=5, odd parity, stop2=1, push 0x13 -> 9 cycles 0,1,1,0,0,1,0,1,1, then idle high.
- Back-to-back: parity none, stop2=1, push 0x00 then 0xFF -> two 11-cycle frames with no idle cycle between; done_flag pulses exactly 11 cycles apart; active_flag continuously high for 22 cycles.
- Overrun: tx_en=0, FIFO_DEPTH=4, push 5 words on consecutive cycles -> fifo_level=4, wr_ready=0 on the 5th, overrun pulses once, data_tx stays 1. Raise tx_en -> exactly 4 frames are sent, in push order.
- Reset mid-frame: assert rst_n low during data bit 3 -> data_tx=1, active_flag=0 and fifo_level=0 immediately (before the next edge). After release, the line stays idle until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings for the UART transmit framer
//
// Purpose: parity mode encodings, transmit FSM state type, idle line level
// and a small helper shared by the framer and its FIFO.
// Ports: none (package).
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Idle / stop level of the serial line.
  localparam logic MARK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Mode 11 is reserved and must behave like "none".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - write-side handshake bundle for the TX framer
//
// Purpose: groups the host word stream into the framer FIFO.
// Signals: wr_data (word), wr_valid (word present), wr_ready (FIFO not full).
// Modports: master = host side, slave = framer side.
interface uart_tx_framer_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous word FIFO feeding the TX framer
//
// Purpose: DATA_W x DEPTH storage with push/pop and an occupancy count.
// Ports: clk, rst_n (async, active-low), push/push_data in, pop in,
//        pop_data out (head word, valid when not empty), level, full, empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leave the count unchanged.
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - parametrised UART transmit framer with input FIFO
//
// Purpose: frames FIFO words as start + DATA_W data (LSB first) + optional
// parity + 1/2 stop bits, one bit per baud_clk edge, back-to-back when fed.
// Ports: baud_clk, rst_n (async, active-low); wr_if (slave: wr_data,
//        wr_valid, wr_ready); tx_en, parity_mode, stop2 config inputs;
//        data_tx line, active_flag, done_flag, overrun, fifo_level outputs.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   baud_clk,
  input  logic                   rst_n,
  uart_tx_framer_if.slave        wr_if,
  input  logic                   tx_en,
  input  logic [1:0]             parity_mode,
  input  logic                   stop2,
  output logic                   data_tx,
  output logic                   active_flag,
  output logic                   done_flag,
  output logic                   overrun,
  output logic [LVL_W-1:0]       fifo_level
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              fifo_full, fifo_empty, fifo_push, pop;
  logic [DATA_W-1:0] fifo_rd_data;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              data_tx_q, data_tx_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              start_frame;

  assign wr_if.wr_ready = !fifo_full;
  assign fifo_push      = wr_if.wr_valid && !fifo_full;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk       (baud_clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (wr_if.wr_data),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    stop_cnt_d  = stop_cnt_q;
    data_tx_d   = data_tx_q;
    active_d    = active_q;
    done_d      = 1'b0;
    overrun_d   = wr_if.wr_valid && fifo_full;
    start_frame = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_tx_d = MARK;
        active_d  = 1'b0;
        if (tx_en && !fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        data_tx_d = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        // Line currently shows data bit bit_cnt_q; the edge loads the next slot.
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          if (par_en_q) begin
            data_tx_d = par_bit_q;
            state_d   = ST_PARITY;
          end else begin
            data_tx_d  = MARK;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end
        end else begin
          data_tx_d = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        data_tx_d  = MARK;
        stop_cnt_d = 1'b0;
        state_d    = ST_STOP;
      end
      ST_STOP: begin
        if (stop2_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          done_d = 1'b1;
          if (tx_en && !fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            data_tx_d = MARK;
            active_d  = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        data_tx_d = MARK;
        active_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Pop and latch the frame config; parity is computed here because the
    // shift register no longer holds the whole word when the parity slot comes.
    if (start_frame) begin
      pop       = 1'b1;
      shift_d   = fifo_rd_data;
      par_en_d  = parity_enabled(parity_mode);
      par_bit_d = (^fifo_rd_data) ^ (parity_mode == PAR_ODD);
      stop2_d   = stop2;
      data_tx_d = ~MARK;
      active_d  = 1'b1;
      state_d   = ST_START;
    end
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      data_tx_q  <= MARK;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      data_tx_q  <= data_tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_tx     = data_tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;
  import uart_pkg::*;

  logic baud_clk = 1'b0;
  logic rst_n;
  always #5 baud_clk = ~baud_clk;

  // Instance a: DATA_W=8
  uart_tx_framer_if #(.DATA_W(8)) a_if ();
  logic       a_tx_en, a_stop2, a_line, a_active, a_done, a_ovr;
  logic [1:0] a_par;
  logic [2:0] a_lvl;

  uart_tx_framer #(.DATA_W(8), .FIFO_DEPTH(4)) dut_a (
    .baud_clk    (baud_clk),
    .rst_n       (rst_n),
    .wr_if       (a_if.slave),
    .tx_en       (a_tx_en),
    .parity_mode (a_par),
    .stop2       (a_stop2),
    .data_tx     (a_line),
    .active_flag (a_active),
    .done_flag   (a_done),
    .overrun     (a_ovr),
    .fifo_level  (a_lvl)
  );

  // Instance b: DATA_W=5
  uart_tx_framer_if #(.DATA_W(5)) b_if ();
  logic       b_tx_en, b_stop2, b_line, b_active, b_done, b_ovr;
  logic [1:0] b_par;
  logic [2:0] b_lvl;

  uart_tx_framer #(.DATA_W(5), .FIFO_DEPTH(4)) dut_b (
    .baud_clk    (baud_clk),
    .rst_n       (rst_n),
    .wr_if       (b_if.slave),
    .tx_en       (b_tx_en),
    .parity_mode (b_par),
    .stop2       (b_stop2),
    .data_tx     (b_line),
    .active_flag (b_active),
    .done_flag   (b_done),
    .overrun     (b_ovr),
    .fifo_level  (b_lvl)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    a_if.wr_data  = d;
    a_if.wr_valid = 1'b1;
    @(negedge baud_clk);
    a_if.wr_valid = 1'b0;
  endtask

  task automatic push_b(input logic [4:0] d);
    b_if.wr_data  = d;
    b_if.wr_valid = 1'b1;
    @(negedge baud_clk);
    b_if.wr_valid = 1'b0;
  endtask

  // Checks len cycles of the line starting at the current negedge. line and
  // dmask are in time order, MSB = first cycle. Then expects the done pulse.
  task automatic check_frame(input string name, input bit sel, input int len,
                             input logic [63:0] line, input logic [63:0] dmask);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge baud_clk);
      check($sformatf("%s line[%0d]", name, i), 64'(sel ? b_line : a_line), 64'(line[len-1-i]));
      check($sformatf("%s active[%0d]", name, i), 64'(sel ? b_active : a_active), 64'd1);
      check($sformatf("%s done[%0d]", name, i), 64'(sel ? b_done : a_done), 64'(dmask[len-1-i]));
    end
    @(negedge baud_clk);
    check({name, " done_end"}, 64'(sel ? b_done : a_done), 64'd1);
    check({name, " active_end"}, 64'(sel ? b_active : a_active), 64'd0);
    check({name, " idle_end"}, 64'(sel ? b_line : a_line), 64'd1);
    @(negedge baud_clk);
    check({name, " done_once"}, 64'(sel ? b_done : a_done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    a_if.wr_valid = 1'b0; a_if.wr_data = '0;
    b_if.wr_valid = 1'b0; b_if.wr_data = '0;
    a_tx_en = 1'b1; a_par = PAR_EVEN; a_stop2 = 1'b0;
    b_tx_en = 1'b1; b_par = PAR_ODD;  b_stop2 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst line", 64'(a_line), 64'd1);
    check("rst active", 64'(a_active), 64'd0);
    check("rst done", 64'(a_done), 64'd0);
    check("rst overrun", 64'(a_ovr), 64'd0);
    check("rst level", 64'(a_lvl), 64'd0);
    check("rst ready", 64'(a_if.wr_ready), 64'd1);
    repeat (2) @(negedge baud_clk);
    rst_n = 1'b1;
    @(negedge baud_clk);

    // 0xA5, even parity, one stop bit
    push_a(8'hA5);
    @(negedge baud_clk);
    check_frame("a5_even", 1'b0, 11, 64'(11'b01010010101), 64'd0);

    // 0x01 odd / even / none / reserved
    a_par = PAR_ODD;
    push_a(8'h01);
    @(negedge baud_clk);
    check_frame("01_odd", 1'b0, 11, 64'(11'b01000000001), 64'd0);
    a_par = PAR_EVEN;
    push_a(8'h01);
    @(negedge baud_clk);
    check_frame("01_even", 1'b0, 11, 64'(11'b01000000011), 64'd0);
    a_par = PAR_NONE;
    push_a(8'h01);
    @(negedge baud_clk);
    check_frame("01_none", 1'b0, 10, 64'(10'b0100000001), 64'd0);
    a_par = 2'b11;
    push_a(8'h01);
    @(negedge baud_clk);
    check_frame("01_rsvd", 1'b0, 10, 64'(10'b0100000001), 64'd0);

    // DATA_W=5, 0x13, odd parity, two stop bits
    push_b(5'h13);
    @(negedge baud_clk);
    check_frame("b13_odd", 1'b1, 9, 64'(9'b011001011), 64'd0);
    check("b13 idle", 64'(b_line), 64'd1);

    // Back-to-back: none, two stop bits, 0x00 then 0xFF
    a_par = PAR_NONE; a_stop2 = 1'b1;
    push_a(8'h00);
    push_a(8'hFF);
    check_frame("b2b", 1'b0, 22, 64'({11'b00000000011, 11'b01111111111}), 64'd1 << 10);

    // Overrun with tx_en low, then drain four frames in push order
    a_tx_en = 1'b0; a_stop2 = 1'b0;
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    check("ovr level4", 64'(a_lvl), 64'd4);
    check("ovr ready0", 64'(a_if.wr_ready), 64'd0);
    check("ovr pre", 64'(a_ovr), 64'd0);
    push_a(8'h55);
    check("ovr pulse", 64'(a_ovr), 64'd1);
    check("ovr level", 64'(a_lvl), 64'd4);
    check("ovr line", 64'(a_line), 64'd1);
    check("ovr active", 64'(a_active), 64'd0);
    @(negedge baud_clk);
    check("ovr once", 64'(a_ovr), 64'd0);
    a_tx_en = 1'b1;
    @(negedge baud_clk);
    check_frame("drain4", 1'b0, 40,
                64'({10'b0100010001, 10'b0010001001, 10'b0110011001, 10'b0001000101}),
                (64'd1 << 29) | (64'd1 << 19) | (64'd1 << 9));
    check("drain level", 64'(a_lvl), 64'd0);

    // Reset during data bit 3
    a_par = PAR_EVEN;
    push_a(8'hA5);
    push_a(8'h3C);
    check("mid start", 64'(a_line), 64'd0);
    repeat (4) @(negedge baud_clk);
    check("mid bit3", 64'(a_line), 64'd0);
    check("mid level", 64'(a_lvl), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid rst line", 64'(a_line), 64'd1);
    check("mid rst active", 64'(a_active), 64'd0);
    check("mid rst level", 64'(a_lvl), 64'd0);
    check("mid rst ready", 64'(a_if.wr_ready), 64'd1);
    @(negedge baud_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge baud_clk);
      check($sformatf("post rst line[%0d]", i), 64'(a_line), 64'd1);
      check($sformatf("post rst active[%0d]", i), 64'(a_active), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
